// File: rtl/dsp_mem_arbiter_pkg.sv
// dsp_mem_arbiter_pkg: shared bank/requester IDs and return-tag type for the DSP SRAM arbiter
package dsp_mem_arbiter_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_op_e;
  localparam int BANK_SEL_BIT = 15;
  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA = 1'b1;
  typedef struct packed {
    logic valid;
    logic bank;
  } ret_tag_t;
  localparam ret_tag_t TAG_NONE = '{valid: FALSE, bank: BANK1};
endpackage

// File: rtl/dsp_mem_arbiter_bank_arb.sv
// dsp_bank_arb: two-way core/DMA arbiter for one bank with a DMA starvation counter
module dsp_bank_arb
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic c_hit,
  input  logic d_hit,
  output logic c_win,
  output logic d_win
);
  logic [3:0] starve;
  logic dma_due;
  assign dma_due = starve == 4'(STARVE_LIMIT);
  assign d_win = d_hit && (!c_hit || dma_due);
  assign c_win = c_hit && !d_win;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve <= '0;
    else if (d_win) starve <= '0;
    else if (c_hit && d_hit && !dma_due) starve <= starve + 4'd1;
  end
endmodule

// File: rtl/dsp_mem_arbiter.sv
// dsp_mem_arbiter: routes core and DMA requests onto the read-only bank 1 and read/write bank 2
module dsp_mem_arbiter
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int WORD_LEN = 16,
  parameter int ADDR_LEN = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [15:0]         c_addr,
  input  logic [WORD_LEN-1:0] c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [WORD_LEN-1:0] c_rdata,
  output logic                c_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [15:0]         d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_err,
  output logic [ADDR_LEN-1:0] b1_raddr,
  output logic                b1_re,
  input  logic [WORD_LEN-1:0] b1_rdata,
  output logic [ADDR_LEN-1:0] b2_addr,
  output logic                b2_re,
  output logic                b2_we,
  output logic [WORD_LEN-1:0] b2_wdata,
  input  logic [WORD_LEN-1:0] b2_rdata
);
  logic [1:0] c_hit, d_hit, c_win, d_win, c_g, d_g;
  logic c_rd, d_rd;
  ret_tag_t c_tag, d_tag;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign c_hit[g] = c_req && c_addr[BANK_SEL_BIT] == 1'(g);
    assign d_hit[g] = d_req && d_addr[BANK_SEL_BIT] == 1'(g);
    dsp_bank_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
      .clk  (clk),
      .rst  (rst),
      .c_hit(c_hit[g]),
      .d_hit(d_hit[g]),
      .c_win(c_win[g]),
      .d_win(d_win[g])
    );
  end
  // grants are masked during reset so every bank-side output falls to 0 with them
  assign c_g = rst ? 2'b00 : c_win;
  assign d_g = rst ? 2'b00 : d_win;
  assign c_gnt = |c_g;
  assign d_gnt = |d_g;
  assign c_rd = mem_op_e'(c_we) == MEM_READ;
  assign d_rd = mem_op_e'(d_we) == MEM_READ;
  always_comb begin
    b1_re = (c_g[BANK1] && c_rd) || (d_g[BANK1] && d_rd);
    b1_raddr = (c_g[BANK1] && c_rd) ? c_addr[ADDR_LEN-1:0] :
               (d_g[BANK1] && d_rd) ? d_addr[ADDR_LEN-1:0] : '0;
    b2_re = (c_g[BANK2] && c_rd) || (d_g[BANK2] && d_rd);
    b2_we = (c_g[BANK2] && !c_rd) || (d_g[BANK2] && !d_rd);
    b2_addr = c_g[BANK2] ? c_addr[ADDR_LEN-1:0] : d_g[BANK2] ? d_addr[ADDR_LEN-1:0] : '0;
    b2_wdata = (c_g[BANK2] && !c_rd) ? c_wdata : (d_g[BANK2] && !d_rd) ? d_wdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_tag <= TAG_NONE;
      d_tag <= TAG_NONE;
      c_err <= FALSE;
      d_err <= FALSE;
    end else begin
      c_tag <= '{valid: c_gnt && c_rd, bank: c_addr[BANK_SEL_BIT]};
      d_tag <= '{valid: d_gnt && d_rd, bank: d_addr[BANK_SEL_BIT]};
      c_err <= c_g[BANK1] && !c_rd;
      d_err <= d_g[BANK1] && !d_rd;
    end
  end
  assign c_rvalid = c_tag.valid;
  assign d_rvalid = d_tag.valid;
  assign c_rdata = !c_tag.valid ? '0 : c_tag.bank == BANK2 ? b2_rdata : b1_rdata;
  assign d_rdata = !d_tag.valid ? '0 : d_tag.bank == BANK2 ? b2_rdata : b1_rdata;
endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// tb_dsp_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dsp_mem_arbiter;
  localparam int W = 16;
  localparam int A = 15;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_req, c_we, c_gnt, c_rvalid, c_err;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [15:0] c_addr, d_addr;
  logic [W-1:0] c_wdata, c_rdata, d_wdata, d_rdata;
  logic [A-1:0] b1_raddr, b2_addr;
  logic b1_re, b2_re, b2_we;
  logic [W-1:0] b1_rdata, b2_rdata, b2_wdata;
  logic [W-1:0] mem1 [64];
  logic [W-1:0] mem2 [64];
  logic [W-1:0] ref1 [64];
  logic [W-1:0] ref2 [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mem_arbiter #(.WORD_LEN(W), .ADDR_LEN(A), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .b1_raddr(b1_raddr), .b1_re(b1_re), .b1_rdata(b1_rdata),
    .b2_addr(b2_addr), .b2_re(b2_re), .b2_we(b2_we), .b2_wdata(b2_wdata), .b2_rdata(b2_rdata)
  );

  // SRAM models: registered read, write on the clock edge
  always @(posedge clk) begin
    if (b1_re) b1_rdata <= mem1[b1_raddr[5:0]];
    if (b2_re) b2_rdata <= mem2[b2_addr[5:0]];
    if (b2_we) mem2[b2_addr[5:0]] = b2_wdata;
  end

  task automatic set_c(input logic r, input logic w, input logic [15:0] a, input logic [W-1:0] d);
    c_req = r; c_we = w; c_addr = a; c_wdata = d;
  endtask

  task automatic set_d(input logic r, input logic w, input logic [15:0] a, input logic [W-1:0] d);
    d_req = r; d_we = w; d_addr = a; d_wdata = d;
  endtask

  task automatic test_reset();
    set_c(1, 0, 16'h0010, 16'h0);
    set_d(1, 1, 16'h8001, 16'h1234);
    #1;
    checks++;
    if ({c_gnt, d_gnt, b1_re, b2_re, b2_we, c_rvalid, d_rvalid, c_err, d_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000000", {c_gnt, d_gnt, b1_re, b2_re, b2_we, c_rvalid, d_rvalid, c_err, d_err});
    end
    checks++;
    if ({b1_raddr, b2_addr, b2_wdata, c_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h/%h exp all 0", b1_raddr, b2_addr, b2_wdata, c_rdata, d_rdata);
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    set_d(0, 0, 16'h0, 16'h0);
    rst = 1'b0;
  endtask

  task automatic test_dual_bank_read();
    @(negedge clk);
    mem1[16] = 16'h1234;
    mem2[32] = 16'hBEEF;
    set_c(1, 0, 16'h0010, 16'h0);
    set_d(1, 0, 16'h8020, 16'h0);
    #1;
    checks++;
    if ({c_gnt, d_gnt, b1_re, b2_re} !== 4'b1111) begin
      errors++; $display("FAIL dual_gnt got %b exp 1111", {c_gnt, d_gnt, b1_re, b2_re});
    end
    checks++;
    if (b1_raddr !== 15'h0010 || b2_addr !== 15'h0020) begin
      errors++; $display("FAIL dual_addr got %h/%h exp 0010/0020", b1_raddr, b2_addr);
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    set_d(0, 0, 16'h0, 16'h0);
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 16'h1234) begin
      errors++; $display("FAIL dual_c_ret got %b/%h exp 1/1234", c_rvalid, c_rdata);
    end
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL dual_d_ret got %b/%h exp 1/beef", d_rvalid, d_rdata);
    end
    @(negedge clk);
    checks++;
    if ({c_rvalid, d_rvalid} !== 2'b00 || c_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++; $display("FAIL dual_idle got %b/%h/%h exp 00/0/0", {c_rvalid, d_rvalid}, c_rdata, d_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    mem2[0] = 16'h0042;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        set_c(1, 0, 16'h8000, 16'h0);
        set_d(1, 0, 16'h8000, 16'h0);
      end
      #1;
      exp = (i == 4 || i == 9) ? 2'b01 : 2'b10;
      checks++;
      if ({c_gnt, d_gnt} !== exp) begin
        errors++; $display("FAIL starve_cycle%0d got %b exp %b", i, {c_gnt, d_gnt}, exp);
      end
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    set_d(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    set_d(1, 1, 16'h8005, 16'hA5A5);
    #1;
    checks++;
    if ({d_gnt, c_gnt, b2_we, b2_re} !== 4'b1010 || b2_addr !== 15'h0005 || b2_wdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL wr_cycle got %b/%h/%h exp 1010/0005/a5a5", {d_gnt, c_gnt, b2_we, b2_re}, b2_addr, b2_wdata);
    end
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL wr_no_ret got %b/%b exp 0/0", d_rvalid, d_err);
    end
    set_d(0, 0, 16'h0, 16'h0);
    set_c(1, 0, 16'h8005, 16'h0);
    #1;
    checks++;
    if ({c_gnt, b2_re, b2_we} !== 3'b110 || b2_addr !== 15'h0005) begin
      errors++; $display("FAIL rd_cycle got %b/%h exp 110/0005", {c_gnt, b2_re, b2_we}, b2_addr);
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 16'hA5A5) begin
      errors++; $display("FAIL rd_after_wr got %b/%h exp 1/a5a5", c_rvalid, c_rdata);
    end
  endtask

  task automatic test_illegal_write();
    @(negedge clk);
    mem1[3] = 16'h5555;
    mem2[3] = 16'h6666;
    set_c(1, 1, 16'h0003, 16'hFFFF);
    #1;
    checks++;
    if ({c_gnt, b1_re, b2_we, c_err} !== 4'b1000) begin
      errors++; $display("FAIL illwr_cycle got %b exp 1000", {c_gnt, b1_re, b2_we, c_err});
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    checks++;
    if (c_err !== 1'b1 || c_rvalid !== 1'b0 || d_err !== 1'b0) begin
      errors++; $display("FAIL illwr_err got %b/%b/%b exp 1/0/0", c_err, c_rvalid, d_err);
    end
    @(negedge clk);
    checks++;
    if (c_err !== 1'b0) begin
      errors++; $display("FAIL illwr_pulse got %b exp 0", c_err);
    end
    checks++;
    if (mem1[3] !== 16'h5555 || mem2[3] !== 16'h6666) begin
      errors++; $display("FAIL illwr_mem got %h/%h exp 5555/6666", mem1[3], mem2[3]);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    mem1[7] = 16'h0777;
    set_c(1, 0, 16'h0007, 16'h0);
    #1;
    checks++;
    if (c_gnt !== 1'b1 || b1_re !== 1'b1) begin
      errors++; $display("FAIL rstrd_gnt got %b/%b exp 1/1", c_gnt, b1_re);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({c_gnt, d_gnt, b1_re, b2_re, b2_we, c_rvalid, c_err} !== 7'b0 || b1_raddr !== '0 || b2_addr !== '0) begin
      errors++; $display("FAIL rstrd_async got %b/%h/%h exp 0/0/0", {c_gnt, d_gnt, b1_re, b2_re, b2_we, c_rvalid, c_err}, b1_raddr, b2_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({c_gnt, c_rvalid, b1_re} !== 3'b0 || c_rdata !== '0) begin
      errors++; $display("FAIL rstrd_hold got %b/%h exp 000/0", {c_gnt, c_rvalid, b1_re}, c_rdata);
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (c_rvalid !== 1'b0 || c_rdata !== '0) begin
        errors++; $display("FAIL rstrd_release%0d got %b/%h exp 0/0", i, c_rvalid, c_rdata);
      end
    end
  endtask

  task automatic test_lone_dma();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        set_c(1, 0, 16'h8000, 16'h0);
        set_d(1, 0, 16'h8000, 16'h0);
      end
      if (i == 2) set_c(0, 0, 16'h0, 16'h0);
      if (i == 3) begin
        set_c(1, 0, 16'h8000, 16'h0);
        set_d(1, 0, 16'h8000, 16'h0);
      end
      #1;
      exp = (i == 2 || i == 7) ? 2'b01 : 2'b10;
      checks++;
      if ({c_gnt, d_gnt} !== exp) begin
        errors++; $display("FAIL lone_dma_cycle%0d got %b exp %b", i, {c_gnt, d_gnt}, exp);
      end
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    set_d(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_random();
    logic cp = 0, cw = 0, dp = 0, dw = 0, cg, dg, cb, db;
    logic [15:0] ca = 0, da = 0;
    logic [W-1:0] cd = 0, dd = 0, ecd = 0, edd = 0;
    logic erv = 0, edrv = 0, ece = 0, ede = 0;
    int st [2] = '{0, 0};
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 16'($urandom); ref1[i] = mem1[i];
      mem2[i] = 16'($urandom); ref2[i] = mem2[i];
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      checks++;
      if (c_rvalid !== erv || c_rdata !== ecd || c_err !== ece) begin
        errors++; $display("FAIL rand_c_ret cyc%0d got %b/%h/%b exp %b/%h/%b", cyc, c_rvalid, c_rdata, c_err, erv, ecd, ece);
      end
      checks++;
      if (d_rvalid !== edrv || d_rdata !== edd || d_err !== ede) begin
        errors++; $display("FAIL rand_d_ret cyc%0d got %b/%h/%b exp %b/%h/%b", cyc, d_rvalid, d_rdata, d_err, edrv, edd, ede);
      end
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; cw = ($urandom_range(0, 3) == 0);
        ca = {1'($urandom_range(0, 1)), 9'b0, 6'($urandom_range(0, 7))}; cd = 16'($urandom);
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; dw = ($urandom_range(0, 3) == 0);
        da = {1'($urandom_range(0, 1)), 9'b0, 6'($urandom_range(0, 7))}; dd = 16'($urandom);
      end
      set_c(cp, cw, ca, cd);
      set_d(dp, dw, da, dd);
      #1;
      cb = ca[15]; db = da[15];
      cg = cp; dg = dp;
      if (cp && dp && cb == db) begin
        if (st[cb] == LIM) begin cg = 0; st[cb] = 0; end
        else begin dg = 0; st[cb]++; end
      end else if (dp) st[db] = 0;
      checks++;
      if ({c_gnt, d_gnt} !== {cg, dg}) begin
        errors++; $display("FAIL rand_gnt cyc%0d got %b exp %b", cyc, {c_gnt, d_gnt}, {cg, dg});
      end
      erv = cg && !cw; ece = cg && cw && !cb;
      ecd = erv ? (cb ? ref2[ca[5:0]] : ref1[ca[5:0]]) : '0;
      edrv = dg && !dw; ede = dg && dw && !db;
      edd = edrv ? (db ? ref2[da[5:0]] : ref1[da[5:0]]) : '0;
      if (cg && cw && cb) ref2[ca[5:0]] = cd;
      if (dg && dw && db) ref2[da[5:0]] = dd;
      if (cg) cp = 0;
      if (dg) dp = 0;
    end
    @(negedge clk);
    set_c(0, 0, 16'h0, 16'h0);
    set_d(0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_dual_bank_read();
    test_starvation();
    test_write_then_read();
    test_illegal_write();
    test_reset_mid_read();
    test_lone_dma();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_mem_arbiter.md
Name: dsp_mem_arbiter

Overview:
Arbitrates the two DSP data SRAM banks between two requesters: the core memory stage (LD/ST) and the receiver sample DMA port.
- Bank 1 is read-only; bank 2 is read/write.
- Address bit 15 selects the bank (0 = bank 1, 1 = bank 2); bits 14:0 are the SRAM address.
- Requests to different banks are serviced in the same cycle.
- When both requesters target the same bank, core has priority, bounded by a DMA starvation limit.
- Read data returns one cycle after grant.

Parameters:
WORD_LEN, 16, data word width (matches REG_WORD_LEN)
ADDR_LEN, 15, SRAM address width (matches SRAM_ADDR_LEN)
STARVE_LIMIT, 4, consecutive lost DMA conflicts before DMA is forced to win; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
c_req  in  1  core request
c_we  in  1  core write (1) / read (0)
c_addr  in  16  core address; bit 15 = bank select
c_wdata  in  WORD_LEN  core write data
c_gnt  out  1  core grant, combinational, same cycle
c_rvalid  out  1  core read data valid
c_rdata  out  WORD_LEN  core read data
c_err  out  1  core illegal write to bank 1, registered 1-cycle pulse
d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err  —  DMA copies of the core ports, same widths and directions
b1_raddr  out  ADDR_LEN  bank 1 read address
b1_re  out  1  bank 1 read enable
b1_rdata  in  WORD_LEN  bank 1 data, valid the cycle after b1_re
b2_addr  out  ADDR_LEN  bank 2 address
b2_re  out  1  bank 2 read enable
b2_we  out  1  bank 2 write enable
b2_wdata  out  WORD_LEN  bank 2 write data
b2_rdata  in  WORD_LEN  bank 2 data, valid the cycle after b2_re

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all rvalid and err outputs to 0
  - starvation counters to 0
  - return-tag registers to "none"
- While rst is high, all gnt, re and we outputs are forced to 0. Bank address and data outputs are 0 during reset.
- Handshake:
  - The requester holds req, we, addr and wdata stable until it sees gnt high at a rising edge.
  - One grant completes one transfer.
  - Transfer to bank k is req & (addr[15] == k-1).
- Per-bank arbitration (combinational) for bank k:
  - Only one requester targets bank k: it is granted.
  - Both target bank k: DMA wins if starve_k == STARVE_LIMIT; otherwise core wins.
- Starvation counter starve_k (registered, per bank):
  - Increments when DMA loses a conflict on bank k.
  - Clears to 0 when DMA is granted on bank k.
  - Holds otherwise.
  - Saturates at STARVE_LIMIT.
- Illegal write: a granted write with addr[15] == 0.
  - b1_re stays 0 and nothing is written.
  - The grant is still issued, so the requester is not stuck.
  - The requester's err is high for exactly the following cycle.
- Granted legal write to bank 2: b2_we = 1, b2_addr = addr[14:0] and b2_wdata = wdata in the grant cycle. No rvalid is produced.
- Granted read:
  - re = 1 for the bank and bank address driven in the grant cycle.
  - A registered return tag (bank, requester) is captured.
  - Next cycle: requester rvalid = 1 and rdata = that bank's rdata.
  - rdata is 0 when rvalid = 0.
- Throughput: each requester can be granted every cycle.
- Both requesters reading different banks in the same cycle: both rvalid assert together in the next cycle.
- Reset asserted during an outstanding read: the return is discarded and no rvalid is issued after reset releases.
- No write-read forwarding: a same-cycle bank 2 conflict is serialized by arbitration, so ordering is grant order.

Decomposition:
- Shared definitions file (alongside TRUE/FALSE and the MEM_* codes):
  - BANK_SEL_BIT = 15
  - bank IDs BANK1 = 0, BANK2 = 1
  - requester IDs REQ_CORE = 0, REQ_DMA = 1
- Sub-module dsp_bank_arb: the per-bank two-way arbiter with its starvation counter. It is instantiated twice.
- The top level holds the address/enable muxing, return tags, rdata steering and error pulses.

Test Plan:
1. Core reads 0x0010 and DMA reads 0x8020 in the same cycle, bank1[0x10] = 0x1234, bank2[0x20] = 0xBEEF -> both gnt in cycle 0; cycle 1: c_rvalid = 1, c_rdata = 0x1234, d_rvalid = 1, d_rdata = 0xBEEF.
2. Core and DMA both continuously request reads of 0x8000, STARVE_LIMIT = 4 -> core granted cycles 0–3, DMA granted cycle 4, core again cycles 5–8, DMA cycle 9.
3. DMA writes 0xA5A5 to 0x8005, then core reads 0x8005 the next cycle -> b2_we pulse with b2_addr = 0x0005; core c_rdata = 0xA5A5 one cycle after its grant.
4. Core writes 0x0003 with data 0xFFFF -> c_gnt = 1, b1_re = 0, b2_we = 0, c_err = 1 for exactly one cycle; bank contents unchanged.
5. Core read of 0x0007 is granted, then rst is asserted asynchronously mid-cycle before the next edge -> no c_rvalid after release; all outputs are 0 while rst is high.
6. DMA lone request to bank 2 while core idles -> d_gnt in the same cycle; starve counter stays 0 (checked by a subsequent conflict resolving to core).
